// File: rtl/syscall_unit.sv
// Environment-call handler: decodes function code A/argument B into LED writes,
// console FIFO pushes, input/cycle-counter reads on eret, and an ordered halt.
module syscall_unit #(
    parameter int XLEN       = 32,
    parameter int LED_CH     = 2,
    parameter int IN_CH      = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ecall,
    input  logic [XLEN-1:0]         A,
    input  logic [XLEN-1:0]         B,
    output logic [XLEN-1:0]         eret,
    output logic                    stall,
    input  logic [IN_CH*XLEN-1:0]   in_data,
    output logic [LED_CH*XLEN-1:0]  ledData,
    output logic                    nHalt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_data,
    output logic                    out_tag
);

    // state   | meaning
    // S_RUN   | calls accepted normally
    // S_DRAIN | halt requested; calls blocked, FIFO keeps emptying
    // S_HALTED| nHalt low, counter frozen; left only through rst
    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    state_t               state_q;
    logic                 nhalt_q;
    logic [XLEN-1:0]      cyc_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [AW-1:0]        wr_q, rd_q;
    logic [XLEN:0]        mem_q [FIFO_DEPTH];
    logic [LED_CH*XLEN-1:0] led_q;

    logic is_push, full, acc, push, pop;
    logic [XLEN:0] push_data;

    assign is_push   = (A == XLEN'(32'h01)) | (A == XLEN'(32'h0B));
    assign full      = (cnt_q == CW'(FIFO_DEPTH));
    assign out_valid = (cnt_q != '0);
    assign stall     = (state_q != S_RUN) | (ecall & is_push & full & ~out_ready);
    assign acc       = ecall & ~stall;
    assign push      = acc & is_push;
    assign pop       = out_valid & out_ready;
    assign push_data = (A == XLEN'(32'h01)) ? {1'b0, B}
                                            : {1'b1, {(XLEN-8){1'b0}}, B[7:0]};

    assign out_data = mem_q[rd_q][XLEN-1:0];
    assign out_tag  = mem_q[rd_q][XLEN];
    assign ledData  = led_q;
    assign nHalt    = nhalt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_comb begin
        eret = '0;
        if (A == XLEN'(32'h20)) begin
            eret = cyc_q;
        end
        for (int k = 0; k < IN_CH; k++) begin
            if (A == XLEN'(32'h80 + k)) begin
                eret = in_data[k*XLEN +: XLEN];
            end
        end
    end

    // Halt is taken on the edge the FIFO becomes empty, so nHalt falls with the last pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            nhalt_q <= 1'b1;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (acc && (A == XLEN'(32'h0A))) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (cnt_d == '0) begin
                        state_q <= S_HALTED;
                        nhalt_q <= 1'b0;
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cyc_q <= '0;
            led_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            if (nhalt_q) begin
                cyc_q <= cyc_q + XLEN'(1);
            end
            for (int k = 0; k < LED_CH; k++) begin
                if (acc && (A == XLEN'(32'h22 + k))) begin
                    led_q[k*XLEN +: XLEN] <= B;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_syscall_unit.sv
// Scoreboard bench for syscall_unit: console pushes are queued when accepted and
// compared as the consumer pops them; LED, eret, stall and halt checked directly.
module tb_syscall_unit;

    logic        clk = 1'b0;
    logic        rst, ecall, out_ready;
    logic [31:0] A, B, eret, out_data;
    logic        stall, nHalt, out_valid, out_tag;
    logic [63:0] in_data, ledData;

    int n_cmp = 0;
    int n_err = 0;
    int w;
    logic [32:0] sb [$];
    logic [32:0] sb_head;
    logic [31:0] exp_cyc;
    bit          exp_run = 1'b0;

    syscall_unit #(.XLEN(32), .LED_CH(2), .IN_CH(2), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .ecall(ecall), .A(A), .B(B), .eret(eret),
        .stall(stall), .in_data(in_data), .ledData(ledData), .nHalt(nHalt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) exp_cyc <= 32'd0;
        else if (exp_run) exp_cyc <= exp_cyc + 32'd1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pops happen at the next posedge; sample at the preceding negedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(out_data), 64'hDEAD_0000);
            end else begin
                sb_head = sb.pop_front();
                check("out_data", 64'(out_data), 64'(sb_head[31:0]));
                check("out_tag", 64'(out_tag), 64'(sb_head[32]));
            end
        end
    end

    // Entry and exit at posedge+1.
    task automatic do_call(input logic [31:0] a, input logic [31:0] b, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        ecall = 1'b1; A = a; B = b;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!stall) begin ok = 1'b1; break; end
            waited++;
            @(posedge clk); #1;
        end
        check("call_accept", 64'(ok), 64'd1);
        if (ok) begin
            if (a == 32'h01) sb.push_back({1'b0, b});
            else if (a == 32'h0B) sb.push_back({1'b1, 24'd0, b[7:0]});
        end
        @(posedge clk); #1;
        ecall = 1'b0;
    endtask

    task automatic eret_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ecall = 1'b0; A = a;
        @(negedge clk);
        check(tag, 64'(eret), 64'(exp));
        @(posedge clk); #1;
    endtask

    task automatic wait_empty(input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!out_valid) begin done = 1'b1; break; end
        end
        check({tag, "_drained"}, 64'(done), 64'd1);
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ecall = 1'b0; A = '0; B = '0; out_ready = 1'b0;
        in_data = {32'h22, 32'h11};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; exp_run = 1'b1; A = 32'h20;
        @(negedge clk);
        check("rst_led", ledData, 64'd0);
        check("rst_nhalt", 64'(nHalt), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_cyc", 64'(eret), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        check("cyc10", 64'(eret), 64'd10);
        check("cyc_model", 64'(eret), 64'(exp_cyc));
        @(posedge clk); #1;

        do_call(32'h22, 32'h1234, w);
        check("led0_wait", 64'(w), 64'd0);
        check("led0", 64'(ledData[31:0]), 64'h1234);
        do_call(32'h23, 32'hBEEF, w);
        check("led1_wait", 64'(w), 64'd0);
        check("led1", 64'(ledData[63:32]), 64'hBEEF);
        check("led0_keep", 64'(ledData[31:0]), 64'h1234);

        eret_chk("eret_in1", 32'h81, 32'h22);
        eret_chk("eret_in0", 32'h80, 32'h11);
        eret_chk("eret_in2", 32'h82, 32'h0);
        eret_chk("eret_push", 32'h01, 32'h0);
        eret_chk("eret_led", 32'h22, 32'h0);

        // Fill the FIFO, then hold a ninth push against a stalled consumer.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) do_call(32'h01, 32'(i), w);
        ecall = 1'b1; A = 32'h01; B = 32'd8;
        @(negedge clk);
        check("full_stall", 64'(stall), 64'd1);
        check("full_head", 64'(out_data), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("full_stall2", 64'(stall), 64'd1);
        check("full_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("ninth_accept", 64'(stall), 64'd0);
        if (!stall) sb.push_back({1'b0, 32'd8});
        @(posedge clk); #1;
        ecall = 1'b0;
        wait_empty("fill");

        do_call(32'h0B, 32'h1FF41, w);
        wait_empty("char");

        // Ordered halt with three entries pending.
        out_ready = 1'b0;
        do_call(32'h01, 32'hA0, w);
        do_call(32'h01, 32'hA1, w);
        do_call(32'h0B, 32'h1C2, w);
        do_call(32'h0A, 32'h0, w);
        ecall = 1'b1; A = 32'h22; B = 32'hDEAD;
        @(negedge clk);
        check("drain_stall", 64'(stall), 64'd1);
        check("drain_nhalt", 64'(nHalt), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("drain_led_blocked", 64'(ledData[31:0]), 64'h1234);
        check("drain_nhalt2", 64'(nHalt), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 3) exp_run = 1'b0;
            @(negedge clk);
            check($sformatf("halt_edge%0d", k), 64'(nHalt), (k < 3) ? 64'd1 : 64'd0);
        end
        @(posedge clk); #1;
        ecall = 1'b0; A = 32'h20;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        check("halt_cyc_frozen", 64'(eret), 64'(exp_cyc));
        check("halt_stall", 64'(stall), 64'd1);
        check("halt_nhalt", 64'(nHalt), 64'd0);
        check("halt_valid", 64'(out_valid), 64'd0);
        check("halt_sb", 64'(sb.size()), 64'd0);
        @(posedge clk); #1;

        // Leave HALTED, then reset again in the middle of a drain.
        out_ready = 1'b0;
        rst = 1'b1; exp_run = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        do_call(32'h22, 32'h55, w);
        check("post_halt_led", 64'(ledData[31:0]), 64'h55);
        do_call(32'h01, 32'h1, w);
        do_call(32'h01, 32'h2, w);
        do_call(32'h0A, 32'h0, w);
        @(negedge clk);
        check("mid_drain_stall", 64'(stall), 64'd1);
        check("mid_drain_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check("rst2_nhalt", 64'(nHalt), 64'd1);
        check("rst2_valid", 64'(out_valid), 64'd0);
        check("rst2_led", ledData, 64'd0);
        check("rst2_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        do_call(32'h22, 32'h77, w);
        check("rst2_call_wait", 64'(w), 64'd0);
        check("rst2_led0", 64'(ledData[31:0]), 64'h77);

        // LED write coinciding with a pop.
        do_call(32'h01, 32'h33, w);
        out_ready = 1'b1;
        do_call(32'h23, 32'h99, w);
        check("sim_led1", 64'(ledData[63:32]), 64'h99);
        wait_empty("sim");
        eret_chk("final_cyc", 32'h20, exp_cyc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/syscall_unit.md
Name: syscall_unit

Overview:
- Parametrised environment-call handler between the CPU ecall path and board I/O.
- Decodes function code A with argument B and drives LED channels.
- Buffers console output (print-int / print-char) in a FIFO towards a display/UART consumer, with a valid/ready handshake.
- Returns input-channel values and a cycle counter on eret; performs an ordered halt that drains the FIFO before deasserting nHalt.

Parameters:
- XLEN, 32, data width of A, B, eret, LED and input channels.
- LED_CH, 2, number of LED output channels (1..8).
- IN_CH, 2, number of input channels (1..8).
- FIFO_DEPTH, 8, console FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ecall  in  1  CPU presents a syscall this cycle; held high by the CPU while stall=1.
- A  in  XLEN  function code.
- B  in  XLEN  argument.
- eret  out  XLEN  return value, combinational from A.
- stall  out  1  CPU must hold the current ecall and freeze.
- in_data  in  IN_CH*XLEN  input channels; channel k = bits [k*XLEN +: XLEN].
- ledData  out  LED_CH*XLEN  LED channels, registered.
- nHalt  out  1  1 = run, 0 = halted.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  XLEN  FIFO head payload.
- out_tag  out  1  head type: 0 = int, 1 = char.

Behaviour:
- Reset (rst=1 at posedge): ledData=0 all channels; nHalt=1; FIFO empty (out_valid=0); cycle counter=0; state=RUN; stall=0. rst overrides every other input.
- Accepted call: acc = ecall & ~stall. Side effects occur only on acc, exactly once per call.
- Function codes:
  - 0x0A: halt request, RUN->DRAIN.
  - 0x01: push {tag=0, B}.
  - 0x0B: push {tag=1, zero-extended B[7:0]}.
  - 0x22+k, k<LED_CH: ledData[k] <= B at the next edge.
  - 0x80+k, k<IN_CH: eret = in_data[k].
  - 0x20: eret = cycle counter.
  - All other codes: no effect, eret=0.
  - eret is 0 for every code not listed as returning a value, regardless of ecall.
- Stall:
  - stall = (state==DRAIN) | (state==HALTED) | (ecall & is_push & full & ~out_ready).
  - The out_ready->stall path is combinational.
  - When full and out_ready=1, push and pop occur in the same cycle and the count is unchanged.
- FIFO:
  - Pop on out_valid & out_ready; out_data/out_tag show the head while out_valid=1.
  - Pointers wrap modulo FIFO_DEPTH; separate count register holds 0..FIFO_DEPTH.
  - Push on empty: visible as out_valid=1 the next cycle (1-cycle latency).
- State machine:
  - RUN: accepted 0x0A -> DRAIN.
  - DRAIN: stall=1, FIFO pops continue, no new calls accepted; when count==0 -> HALTED at that edge.
  - HALTED: nHalt=0, stall=1; the only exit is rst.
  - nHalt=0 is a registered output that falls on the edge entering HALTED.
  - A 0x0A call with the FIFO already empty gives RUN->DRAIN->HALTED: nHalt falls 2 edges after acceptance.
- Cycle counter: XLEN bits, increments every cycle while nHalt=1, wraps 2^XLEN-1 -> 0, holds in HALTED.
- Reset mid-drain or mid-halt: returns to RUN with an empty FIFO; buffered entries are discarded.
- Simultaneous LED write and pop: independent, both take effect.

Test Plan:
- Reset then ecall A=0x22 B=0x1234, then A=0x23 B=0xBEEF -> ledData[0]=0x1234, ledData[1]=0xBEEF one cycle after each call; stall stays 0.
- in_data ch0=0x11, ch1=0x22; A=0x81 (no ecall) -> eret=0x22; A=0x82 -> eret=0; A=0x20 after 10 cycles from reset -> eret=10.
- out_ready=0; push 8 calls A=0x01 B=0..7, then a 9th call with B=8 -> stall=1 and count stays 8. Raise out_ready -> 9th call accepted that cycle. Drain order 0..8, all out_tag=0.
- A=0x0B B=0x1FF41 -> out_data=0x41, out_tag=1.
- Three pushes with out_ready=0, then A=0x0A -> stall=1 and nHalt=1. With out_ready=1, nHalt falls on the edge the last entry pops. Cycle counter frozen; stall stays 1.
- Assert rst in DRAIN with 2 entries queued -> nHalt=1, out_valid=0, ledData=0, and normal calls are accepted the next cycle.
